input_fetch_ctrl: RTL and testbench
===================================

// Module: input_fetch_ctrl
// PURPOSE
//  Sequencer and arbiter for the 512x16 input RAM. It streams a burst of input words (base, length) to the
//  neuron/MAC datapath over a valid/ready handshake. It also shares the single RAM port with the host loader
//  write path. Sits between the host loader, the layer scheduler (start/done) and the input RAM.
// PARAMETERS
//  ADDR_W   9   RAM address width (depth 2**ADDR_W)
//  DATA_W   16  word width
//  LEN_W    10  burst length width (0..512)
// PORTS
//  clock          in   1       single clock; all state changes on posedge
//  reset_n        in   1       asynchronous, active-low reset
//  start          in   1       pulse: begin burst; ignored while busy=1
//  base_addr      in   ADDR_W  first RAM address of burst, sampled on accepted start
//  length         in   LEN_W   word count, sampled on accepted start
//  busy           out  1       high from the cycle after accepted start until done
//  done           out  1       one-cycle pulse after the last word is consumed
//  out_data       out  DATA_W  streamed word (registered)
//  out_valid      out  1       out_data valid
//  out_ready      in   1       consumer accepts out_data when out_valid & out_ready
//  host_wr_req    in   1       host requests a RAM write; held until granted
//  host_wr_addr   in   ADDR_W  host write address
//  host_wr_data   in   DATA_W  host write data
//  host_wr_gnt    out  1       combinational grant; write commits at this posedge
//  ram_address    out  ADDR_W  to RAM address
//  ram_write_data out  DATA_W  to RAM write_data (= host_wr_data)
//  ram_enable     out  1       high on any read-capture or write cycle
//  ram_write      out  1       = host_wr_gnt
//  ram_read_data  in   DATA_W  from RAM (combinational read, settles <4ns; clock period must exceed this)
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, out_valid=0, out_data=0, rd_addr=0, remaining=0; grant/RAM strobes low.
//  FSM: IDLE -start-> FETCH (length>0) | DONE (length==0). FETCH -last word captured-> DRAIN.
//       DRAIN -last word handshaken-> DONE. DONE -> IDLE after 1 cycle (done=1 that cycle only).
//  Read path: in FETCH ram_address=rd_addr (registered, stable for the whole cycle).
//   - out_free = !out_valid | out_ready.
//   - At posedge with out_free & !host_wr_gnt: out_data<=ram_read_data, out_valid<=1,
//     rd_addr<=rd_addr+1 (mod 512, 511 wraps to 0), remaining<=remaining-1.
//   - Throughput: 1 word/cycle with out_ready held high. First out_valid appears 1 cycle after entering FETCH.
//  Arbitration: host_wr_gnt = host_wr_req & (state!=FETCH | !out_free).
//   - The host always wins in IDLE/DRAIN/DONE and in stalled FETCH cycles.
//   - The streaming read wins in productive FETCH cycles.
//   - While granted, ram_address=host_wr_addr and no capture happens in that cycle.
//   - Write/read ordering at the same address is a host concern; no hazard check.
//  out_valid clears on a handshake when no new capture occurs in the same cycle.
//  start while busy: ignored, no error. start and host_wr_req in the same IDLE cycle: both proceed.
//  Async reset mid-burst: immediate return to IDLE, out_valid drops, burst is abandoned.
//  busy=1 in FETCH/DRAIN/DONE.
// CONFIGURATION
//  INFETCH_STRIDE_EN defined:
//   - adds input stride[ADDR_W-1:0], sampled with start.
//   - rd_addr advances by stride (mod 512); stride 0 repeats base_addr for the full length.
//  Not defined: no stride port; increment is fixed at 1.
// STRUCTURE
//  Shared package input_ctrl_pkg: fetch_state_t enum (IDLE, FETCH, DRAIN, DONE) and the RAM geometry constants
//  (INPUT_ADDR_W=9, INPUT_DATA_W=16, INPUT_DEPTH=512).
//  One sub-module: infetch_out_reg, the single-entry output register with the valid/ready logic and out_free.
//  FSM, address counter and arbiter stay in the top module.
// TESTING
//  1 Preload RAM[10..13]=A,B,C,D; start base=10 len=4, out_ready=1
//    -> out_data A,B,C,D on 4 consecutive cycles; done pulses once; busy falls.
//  2 base=510 len=4 -> words from addresses 510,511,0,1 in that order.
//  3 len=0 -> out_valid never asserts; done pulses 2 cycles after start.
//  4 Burst len=8 with out_ready toggling 1,0,1,0 plus host_wr_req held
//    -> writes granted only in stalled cycles; 8 words arrive in order, none lost or duplicated.
//  5 Assert reset_n=0 at word 3 of a len=8 burst -> immediately out_valid=0, busy=0;
//    after release, a new start works normally.
//  6 (INFETCH_STRIDE_EN) base=0 stride=3 len=4 -> words from addresses 0,3,6,9.

Source files
------------

// File: rtl/input_ctrl_pkg.sv
// Shared types and RAM geometry for the input RAM fetch path.
// No logic; latency and backpressure not applicable.
// Imported by the fetch controller, its interface and its bench.
package input_ctrl_pkg;
    localparam int INPUT_ADDR_W = 9;
    localparam int INPUT_DATA_W = 16;
    localparam int INPUT_DEPTH  = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;
endpackage

// File: rtl/input_fetch_ctrl_if.sv
// Bundle of scheduler, stream, host-write and RAM signals around the fetch controller.
// Wires only; no latency. Stream uses valid/ready, host write uses req/grant.
// Stride port exists only when INFETCH_STRIDE_EN is defined.
interface input_fetch_ctrl_if
    import input_ctrl_pkg::*;
#(
    parameter int ADDR_W = INPUT_ADDR_W,
    parameter int DATA_W = INPUT_DATA_W,
    parameter int LEN_W  = 10
) ();
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
`ifdef INFETCH_STRIDE_EN
    logic [ADDR_W-1:0] stride;
`endif
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              host_wr_req;
    logic [ADDR_W-1:0] host_wr_addr;
    logic [DATA_W-1:0] host_wr_data;
    logic              host_wr_gnt;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_write_data;
    logic              ram_enable;
    logic              ram_write;
    logic [DATA_W-1:0] ram_read_data;

    modport master (
        input  start, base_addr, length,
`ifdef INFETCH_STRIDE_EN
        input  stride,
`endif
        input  out_ready, host_wr_req, host_wr_addr, host_wr_data, ram_read_data,
        output busy, done, out_data, out_valid, host_wr_gnt,
        output ram_address, ram_write_data, ram_enable, ram_write
    );

    modport slave (
        output start, base_addr, length,
`ifdef INFETCH_STRIDE_EN
        output stride,
`endif
        output out_ready, host_wr_req, host_wr_addr, host_wr_data, ram_read_data,
        input  busy, done, out_data, out_valid, host_wr_gnt,
        input  ram_address, ram_write_data, ram_enable, ram_write
    );
endinterface

// File: rtl/infetch_out_reg.sv
// Single-entry registered output stage for the fetched word stream.
// Latency: one cycle from capture to out_valid.
// Backpressure: out_free tells the fetcher when a capture may overwrite the entry.
module infetch_out_reg #(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              capture,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_free
);
    assign out_free = !out_valid || out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (capture) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/input_fetch_ctrl.sv
// Burst sequencer for the input RAM plus arbiter sharing its port with host writes.
// Latency: first word valid one cycle after entering FETCH, then 1 word/cycle.
// Backpressure: out_ready stalls capture; host writes take stalled and non-FETCH cycles.
// Optional INFETCH_STRIDE_EN adds a per-burst address stride.
module input_fetch_ctrl
    import input_ctrl_pkg::*;
#(
    parameter int ADDR_W = INPUT_ADDR_W,
    parameter int DATA_W = INPUT_DATA_W,
    parameter int LEN_W  = 10
) (
    input  logic                clock,
    input  logic                reset_n,
    input_fetch_ctrl_if.master  bus
);
    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] addr_inc;
    logic [LEN_W-1:0]  remaining;
    logic              out_free;
    logic              start_ok;
    logic              capture;
    logic              last_capture;
    logic              handshake;

    assign start_ok     = (state == IDLE) && bus.start;
    assign capture      = (state == FETCH) && out_free && !bus.host_wr_gnt;
    assign last_capture = capture && (remaining == LEN_W'(1));
    assign handshake    = bus.out_valid && bus.out_ready;

`ifdef INFETCH_STRIDE_EN
    logic [ADDR_W-1:0] stride_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            stride_q <= '0;
        else if (start_ok)
            stride_q <= bus.stride;
    end

    assign addr_inc = stride_q;
`else
    assign addr_inc = ADDR_W'(1);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (bus.length != '0) ? FETCH : DONE;
            FETCH:   if (last_capture) state_nxt = DRAIN;
            DRAIN:   if (handshake) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Streaming read owns the port only in FETCH cycles that can actually capture.
    always_comb begin
        bus.busy        = (state != IDLE);
        bus.done        = (state == DONE);
        bus.host_wr_gnt = bus.host_wr_req && ((state != FETCH) || !out_free);
        bus.ram_write   = bus.host_wr_gnt;
        bus.ram_enable  = capture || bus.host_wr_gnt;
        bus.ram_address = bus.host_wr_gnt ? bus.host_wr_addr : rd_addr;
    end

    assign bus.ram_write_data = bus.host_wr_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr   <= '0;
            remaining <= '0;
        end else if (start_ok) begin
            rd_addr   <= bus.base_addr;
            remaining <= bus.length;
        end else if (capture) begin
            rd_addr   <= rd_addr + addr_inc;
            remaining <= remaining - LEN_W'(1);
        end
    end

    infetch_out_reg #(.DATA_W(DATA_W)) u_out_reg (
        .clock     (clock),
        .reset_n   (reset_n),
        .capture   (capture),
        .in_data   (bus.ram_read_data),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_data),
        .out_valid (bus.out_valid),
        .out_free  (out_free)
    );
endmodule

// File: tb/tb_input_fetch_ctrl.sv
// Bench for input_fetch_ctrl: behavioural RAM, host preload, scoreboarded bursts.
module tb_input_fetch_ctrl;
    import input_ctrl_pkg::*;

    logic clock;
    logic reset_n;
    int   total;
    int   bad;

    logic [15:0] mem    [512];
    logic [15:0] shadow [512];
    logic [15:0] exp_q  [$];

    input_fetch_ctrl_if bus ();

    input_fetch_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign bus.ram_read_data = mem[bus.ram_address];

    always @(posedge clock) begin
        if (bus.ram_enable && bus.ram_write)
            mem[bus.ram_address] <= bus.ram_write_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input int addr, input logic [15:0] data);
        @(negedge clock);
        bus.host_wr_req  = 1'b1;
        bus.host_wr_addr = 9'(addr);
        bus.host_wr_data = data;
        #1;
        check("idle_gnt", {31'd0, bus.host_wr_gnt}, 32'd1);
        shadow[addr] = data;
    endtask

    task automatic run_burst(input int base, input int len, input int strd,
                             input bit toggle_rdy, input bit host_on, input bit restart,
                             input int abort_after, input bit check_consec);
        int  hs, mcap, first_hs, last_hs, done_cnt, done_cyc, hk;
        bit  fin, valid_seen, model_fetch, exp_gnt;
        logic [15:0] w;
        hs = 0; mcap = 0; first_hs = 0; last_hs = 0; done_cnt = 0; done_cyc = 0; hk = 0;
        fin = 1'b0; valid_seen = 1'b0;
        exp_q.delete();
        for (int i = 0; i < len; i++)
            exp_q.push_back(shadow[(base + i * strd) % 512]);

        @(negedge clock);
        bus.start     = 1'b1;
        bus.base_addr = 9'(base);
        bus.length    = 10'(len);
`ifdef INFETCH_STRIDE_EN
        bus.stride    = 9'(strd);
`endif
        bus.out_ready = 1'b1;

        for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
            @(negedge clock);
            if (abort_after > 0 && hs >= abort_after) begin
                bus.start       = 1'b0;
                bus.host_wr_req = 1'b0;
                reset_n         = 1'b0;
                #1;
                check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
                check("rst_busy", {31'd0, bus.busy}, 32'd0);
                @(negedge clock);
                reset_n = 1'b1;
                exp_q.delete();
                return;
            end
            bus.start = restart && (cyc == 2);
            if (bus.start) begin
                bus.base_addr = 9'd100;
                bus.length    = 10'd3;
            end
            bus.out_ready    = toggle_rdy ? ((cyc % 2) == 1) : 1'b1;
            bus.host_wr_req  = host_on && (hk < 6) && (done_cnt == 0);
            bus.host_wr_addr = 9'(300 + hk);
            bus.host_wr_data = 16'(16'hC000 + hk);
            #1;
            if (done_cnt > 0) begin
                check("post_done_busy", {31'd0, bus.busy}, 32'd0);
                check("done_once", {31'd0, bus.done}, 32'd0);
                fin = 1'b1;
            end else begin
                model_fetch = (mcap < len);
                exp_gnt = bus.host_wr_req && !(model_fetch && (!bus.out_valid || bus.out_ready));
                if (host_on)
                    check("gnt", {31'd0, bus.host_wr_gnt}, {31'd0, exp_gnt});
                if (bus.host_wr_gnt && bus.host_wr_req) begin
                    check("wr_addr", {23'd0, bus.ram_address}, {23'd0, bus.host_wr_addr});
                    hk++;
                end
                if (model_fetch && (!bus.out_valid || bus.out_ready) && !exp_gnt)
                    mcap++;
                if (bus.out_valid)
                    valid_seen = 1'b1;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("word_count", hs + 1, len);
                    end else begin
                        w = exp_q.pop_front();
                        check("word", {16'd0, bus.out_data}, {16'd0, w});
                    end
                    if (hs == 0) first_hs = cyc;
                    last_hs = cyc;
                    hs++;
                end
                if (bus.done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
        check("finished", {31'd0, fin}, 32'd1);
        check("words", hs, len);
        check("queue_empty", exp_q.size(), 0);
        if (check_consec)
            check("consecutive", last_hs - first_hs, len - 1);
        if (len == 0) begin
            check("no_valid", {31'd0, valid_seen}, 32'd0);
            check("done_early", {31'd0, (done_cyc >= 1 && done_cyc <= 2)}, 32'd1);
        end
        if (host_on) begin
            check("writes_granted", {31'd0, (hk > 0)}, 32'd1);
            for (int i = 0; i < hk; i++) begin
                check("wr_commit", {16'd0, mem[300 + i]}, 32'(16'hC000 + i));
                shadow[300 + i] = 16'(16'hC000 + i);
            end
        end
        bus.host_wr_req = 1'b0;
        bus.start       = 1'b0;
        bus.out_ready   = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n          = 1'b0;
        bus.start        = 1'b0;
        bus.base_addr    = '0;
        bus.length       = '0;
`ifdef INFETCH_STRIDE_EN
        bus.stride       = '0;
`endif
        bus.out_ready    = 1'b0;
        bus.host_wr_req  = 1'b0;
        bus.host_wr_addr = '0;
        bus.host_wr_data = '0;
        #1;
        check("rst_busy0", {31'd0, bus.busy}, 32'd0);
        check("rst_done0", {31'd0, bus.done}, 32'd0);
        check("rst_valid0", {31'd0, bus.out_valid}, 32'd0);
        check("rst_data0", {16'd0, bus.out_data}, 32'd0);
        check("rst_gnt0", {31'd0, bus.host_wr_gnt}, 32'd0);
        check("rst_en0", {31'd0, bus.ram_enable}, 32'd0);
        check("rst_wr0", {31'd0, bus.ram_write}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Preload the whole RAM through the host path; 10..13 get the A..D pattern.
        for (int i = 0; i < 512; i++)
            host_write(i, 16'(16'h5000 + i * 7));
        host_write(10, 16'hAAAA);
        host_write(11, 16'hBBBB);
        host_write(12, 16'hCCCC);
        host_write(13, 16'hDDDD);
        @(negedge clock);
        bus.host_wr_req = 1'b0;

        run_burst(10, 4, 1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        run_burst(510, 4, 1, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        run_burst(20, 0, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_burst(40, 8, 1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        run_burst(60, 8, 1, 1'b0, 1'b0, 1'b0, 3, 1'b0);
        run_burst(10, 4, 1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
`ifdef INFETCH_STRIDE_EN
        run_burst(0, 4, 3, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        run_burst(7, 3, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
